// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and 8N1 frame constants
package uart_pkg;

  // Line-side frame phases, shared by the transmit and receive sides
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clock cycles per bit
  localparam logic [13:0] KBAUD_DEFAULT = 14'd10416;

  // Total clock cycles in one frame for a given bit period
  function automatic int frame_cycles(input int kbaud);
    return kbaud * (1 + DATA_BITS + STOP_BITS);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit byte queue with registered pointers
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer bit separates "full" from "empty" when the indices match
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; a push into a full queue is dropped, a pop from empty ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - queued 8N1 UART transmitter
module uart_tx
  import uart_pkg::*;
#(
  parameter logic [13:0] KBAUD      = KBAUD_DEFAULT,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_tx,
  output logic       Tx_done,
  output logic       busy
);

  localparam int            CW       = (KBAUD > 14'd1) ? $clog2(KBAUD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(KBAUD - 14'd1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bit_end  = (baud_cnt == CNT_LAST);
  assign in_ready = !fifo_full;

  // Pop when leaving IDLE, or at the last stop-bit cycle to chain the next frame
  assign fifo_pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

  // Tx_done marks the stop bit still on the line after the FSM has moved on
  assign busy = (state != IDLE) || !fifo_empty || Tx_done;

  // Frame sequencer; out_tx is registered from the state, so the line lags the FSM by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      out_tx   <= 1'b1;
      Tx_done  <= 1'b0;
    end else begin
      Tx_done <= 1'b0;
      case (state)
        IDLE: begin
          out_tx   <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (fifo_pop) begin
            shreg <= fifo_rdata;
            state <= START;
          end
        end
        START: begin
          out_tx <= 1'b0;
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          out_tx <= shreg[bit_idx];
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          out_tx <= 1'b1;
          if (bit_end) begin
            Tx_done  <= 1'b1;
            baud_cnt <= '0;
            if (fifo_pop) begin
              shreg <= fifo_rdata;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
module tb_uart_tx;

  localparam int KB    = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * KB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       out_tx;
  logic       Tx_done;
  logic       busy;

  uart_tx #(
    .KBAUD      (14'd4),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_tx   (out_tx),
    .Tx_done  (Tx_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int errors = 0;

  // Model: every accepted byte becomes a frame with an acceptance edge and a line start edge
  int         f_acc[$];
  int         f_start[$];
  logic [7:0] f_data[$];
  int         rst_edge  = -1;
  int         line_free = 0;
  bit         model_on  = 1'b0;

  int done_cnt  = 0;
  int last_done = -1;
  int prev_done = -1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // A byte starts on the line two edges after acceptance, or when the previous frame ends
  task automatic add_frame(input int acc_edge, input logic [7:0] d);
    int s;
    s = acc_edge + 2;
    if (line_free > s) s = line_free;
    line_free = s + FRAME;
    f_acc.push_back(acc_edge);
    f_start.push_back(s);
    f_data.push_back(d);
  endtask

  function automatic bit live(input int i, input int t);
    return !(f_acc[i] < rst_edge && t >= rst_edge);
  endfunction

  function automatic logic exp_tx(input int t);
    logic v;
    int   b;
    v = 1'b1;
    foreach (f_start[i]) begin
      if (live(i, t) && t >= f_start[i] && t < f_start[i] + FRAME) begin
        b = (t - f_start[i]) / KB;
        if (b == 0)      v = 1'b0;
        else if (b <= 8) v = f_data[i][b-1];
        else             v = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic logic exp_done(input int t);
    logic v;
    v = 1'b0;
    foreach (f_start[i]) if (live(i, t) && t == f_start[i] + FRAME - 1) v = 1'b1;
    return v;
  endfunction

  function automatic logic exp_busy(input int t);
    logic v;
    v = 1'b0;
    foreach (f_start[i]) if (live(i, t) && t >= f_acc[i] && t < f_start[i] + FRAME) v = 1'b1;
    return v;
  endfunction

  // Queued means accepted but not yet popped; the pop happens one edge before the line start
  function automatic logic exp_ready(input int t);
    int n;
    n = 0;
    foreach (f_start[i]) if (live(i, t) && t >= f_acc[i] && t < f_start[i] - 1) n++;
    return (n < DEPTH);
  endfunction

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (model_on) begin
      check("out_tx",   int'(out_tx),   int'(exp_tx(edge_n)));
      check("Tx_done",  int'(Tx_done),  int'(exp_done(edge_n)));
      check("busy",     int'(busy),     int'(exp_busy(edge_n)));
      check("in_ready", int'(in_ready), int'(exp_ready(edge_n)));
    end
    if (Tx_done) begin
      done_cnt++;
      prev_done = last_done;
      last_done = edge_n;
    end
  end

  // Line receiver: samples each bit two cycles into its period
  bit         dec_en    = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;
  int         frame_err = 0;
  always begin
    @(negedge clk);
    if (dec_en && out_tx == 1'b0) begin
      repeat (2) @(negedge clk);
      if (out_tx != 1'b0) frame_err++;
      for (int k = 0; k < 8; k++) begin
        repeat (KB) @(negedge clk);
        rx_byte[k] = out_tx;
      end
      repeat (KB) @(negedge clk);
      if (out_tx != 1'b1) frame_err++;
      rx_q.push_back(rx_byte);
    end
  end

  // Drive one cycle of input; acceptance is decided by the model's own readiness
  task automatic cycle(input bit v, input logic [7:0] d, output bit acc);
    in_valid = v;
    in_data  = d;
    acc = v && exp_ready(edge_n);
    if (acc) add_frame(edge_n + 1, d);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit         acc;
    int         n;
    int         d0;
    int         low;
    int         i;
    int         k;
    int         acc_e[7];
    logic [9:0] bits;
    logic [7:0] lb[4];

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(posedge clk);
    #2;
    repeat (2) cycle(1'b0, 8'h00, acc);
    rst      = 1'b0;
    model_on = 1'b1;

    // Reset values
    check("rst_out_tx",   int'(out_tx),   1);
    check("rst_Tx_done",  int'(Tx_done),  0);
    check("rst_busy",     int'(busy),     0);
    check("rst_in_ready", int'(in_ready), 1);
    repeat (5) cycle(1'b0, 8'h00, acc);

    // Single byte 0x41: latency, bit pattern, done pulse, busy release
    d0 = done_cnt;
    cycle(1'b1, 8'h41, acc);
    n = edge_n;
    check("t1_accept", int'(acc), 1);
    cycle(1'b0, 8'h00, acc);
    check("t1_tx_n1", int'(out_tx), 1);
    cycle(1'b0, 8'h00, acc);
    check("t1_tx_n2", int'(out_tx), 0);
    bits[0] = out_tx;
    for (int b = 1; b < 10; b++) begin
      repeat (KB) cycle(1'b0, 8'h00, acc);
      bits[b] = out_tx;
    end
    check("t1_frame_bits", int'(bits), int'(10'b1010000010));
    repeat (3) cycle(1'b0, 8'h00, acc);
    check("t1_edge", edge_n - n, 41);
    check("t1_done_n41", int'(Tx_done), 1);
    check("t1_busy_n41", int'(busy), 1);
    cycle(1'b0, 8'h00, acc);
    check("t1_busy_n42", int'(busy), 0);
    check("t1_done_n42", int'(Tx_done), 0);
    check("t1_done_count", done_cnt - d0, 1);
    repeat (4) cycle(1'b0, 8'h00, acc);

    // Back-to-back 0x00, 0xFF
    d0 = done_cnt;
    cycle(1'b1, 8'h00, acc);
    n = edge_n;
    cycle(1'b1, 8'hFF, acc);
    k = 0;
    while (k < 200 && done_cnt < d0 + 2) begin
      cycle(1'b0, 8'h00, acc);
      k++;
    end
    check("t2_done_count", done_cnt - d0, 2);
    check("t2_first_done", prev_done - n, 41);
    check("t2_second_done", last_done - n, 81);
    repeat (4) cycle(1'b0, 8'h00, acc);

    // Full queue: six bytes with in_valid held
    i = 1;
    k = 0;
    while (i <= 6 && k < 200) begin
      cycle(1'b1, 8'(i), acc);
      k++;
      if (acc) begin
        acc_e[i] = edge_n;
        if (i == 5) check("t3_ready_after5", int'(in_ready), 0);
        i++;
      end
    end
    check("t3_accepted", i, 7);
    check("t3_fifth_edge", acc_e[5] - acc_e[1], 4);
    check("t3_sixth_edge", acc_e[6] - acc_e[1], 42);
    repeat (6 * FRAME) cycle(1'b0, 8'h00, acc);

    // Push landing exactly on the stop bit's last cycle with an empty queue
    cycle(1'b1, 8'h3C, acc);
    n = edge_n;
    repeat (40) cycle(1'b0, 8'h00, acc);
    cycle(1'b1, 8'hC3, acc);
    check("t20_accept", int'(acc), 1);
    check("t20_done", int'(Tx_done), 1);
    cycle(1'b0, 8'h00, acc);
    check("t20_gap", int'(out_tx), 1);
    cycle(1'b0, 8'h00, acc);
    check("t20_start", int'(out_tx), 0);
    check("t20_edge", edge_n - n, 43);
    repeat (FRAME + 4) cycle(1'b0, 8'h00, acc);

    // Reset during data bit 3 of 0xA5 with two bytes queued
    cycle(1'b1, 8'hA5, acc);
    n = edge_n;
    cycle(1'b1, 8'h11, acc);
    cycle(1'b1, 8'h22, acc);
    while (edge_n < n + 18) cycle(1'b0, 8'h00, acc);
    check("t4_bit3", int'(out_tx), 0);
    d0        = done_cnt;
    rst       = 1'b1;
    rst_edge  = edge_n + 1;
    line_free = 0;
    cycle(1'b0, 8'h00, acc);
    rst = 1'b0;
    check("t4_out_tx", int'(out_tx), 1);
    check("t4_busy", int'(busy), 0);
    check("t4_in_ready", int'(in_ready), 1);
    check("t4_Tx_done", int'(Tx_done), 0);
    low = 0;
    repeat (100) begin
      cycle(1'b0, 8'h00, acc);
      if (!out_tx) low++;
    end
    check("t4_line_quiet", low, 0);
    check("t4_no_done", done_cnt - d0, 0);

    // Loopback through the line receiver
    lb[0] = 8'h00;
    lb[1] = 8'h55;
    lb[2] = 8'hAA;
    lb[3] = 8'hFF;
    rx_q.delete();
    dec_en = 1'b1;
    d0 = done_cnt;
    for (int j = 0; j < 4; j++) begin
      cycle(1'b1, lb[j], acc);
      check("t5_accept", int'(acc), 1);
    end
    k = 0;
    while (k < 300 && rx_q.size() < 4) begin
      cycle(1'b0, 8'h00, acc);
      k++;
    end
    repeat (4) cycle(1'b0, 8'h00, acc);
    check("t5_rx_count", rx_q.size(), 4);
    check("t5_done_count", done_cnt - d0, 4);
    check("t5_frame_err", frame_err, 0);
    for (int j = 0; j < 4; j++) begin
      if (j < rx_q.size()) check("t5_rx_byte", int'(rx_q[j]), int'(lb[j]));
    end
    check("t5_idle_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
